// File: rtl/fcs_pkg.sv
// Shared constants and types for the receive-path FCS checker and the
// reusable CRC-32 step.
//   CRC_POLY     reflected IEEE 802.3 polynomial
//   CRC_INIT     CRC register value at the start of a frame
//   CRC_RESIDUE  CRC register value after a good frame, FCS included
//   state_t      checker FSM states
//   err_t        itemised end-of-frame error report
package fcs_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE,
    RX
  } state_t;

  typedef struct packed {
    logic fcs;
    logic runt;
    logic giant;
    logic align;
  } err_t;

endpackage

// File: rtl/crc32_step.sv
// Combinational reflected CRC-32 update over one DW-bit beat.
// Data is consumed LSB-first; each bit XORs into bit 0 before the right shift.
//   crc_i   CRC register before the beat
//   data_i  beat data, bit 0 first on the wire
//   crc_o   CRC register after the beat
module crc32_step
  import fcs_pkg::*;
#(
  parameter int unsigned DW = 2
) (
  input  logic [31:0]   crc_i,
  input  logic [DW-1:0] data_i,
  output logic [31:0]   crc_o
);

  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int unsigned i = 0; i < DW; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC_POLY;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/fcs_checker.sv
// Receive-path Ethernet FCS checker. Runs CRC-32 over each frame (a maximal
// run of axiiv=1 beats), then reports pass/fail, length class and alignment
// one cycle after the frame ends, and keeps saturating good/bad counters.
//   clk, rst           clock; synchronous active-high reset
//   axiiv, axiid       beat valid / DW-bit beat data (bit 0 first on wire)
//   done               one-cycle pulse: report below is fresh
//   kill               OR of all error bits, held until next done
//   err_fcs/runt/giant/align  itemised error report, held until next done
//   good_cnt, bad_cnt  saturating frame counters
module fcs_checker
  import fcs_pkg::*;
#(
  parameter int unsigned DW        = 2,
  parameter logic [31:0] RESIDUE   = CRC_RESIDUE,
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1522,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [DW-1:0]    axiid,
  output logic             done,
  output logic             kill,
  output logic             err_fcs,
  output logic             err_runt,
  output logic             err_giant,
  output logic             err_align,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  if (DW != 2 && DW != 8) begin : g_bad_dw
    $error("fcs_checker: DW must be 2 or 8");
  end

  // Beat count saturates at MAX_BYTES+1 bytes, enough to flag a giant.
  localparam int unsigned SAT_BEATS  = (MAX_BYTES + 1) * 8 / DW;
  localparam int unsigned BCW        = $clog2(SAT_BEATS + 1);
  localparam int unsigned BYTE_SHIFT = (DW == 2) ? 2 : 0;
  localparam logic [BCW-1:0] ALIGN_MASK = BCW'(8 / DW - 1);
  localparam logic [BCW-1:0] SAT_CNT    = BCW'(SAT_BEATS);

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d, crc_in, crc_step;
  logic [BCW-1:0]  cnt_q, cnt_d;
  logic [31:0]     bytes;
  logic            report;
  err_t            err_now, err_q;
  logic            done_q;
  logic [CNT_W-1:0] good_q, bad_q;

  // First beat of a frame is folded into INIT directly: no dead cycle.
  assign crc_in = (state_q == IDLE) ? CRC_INIT : crc_q;

  crc32_step #(.DW(DW)) u_step (
    .crc_i  (crc_in),
    .data_i (axiid),
    .crc_o  (crc_step)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    report  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (axiiv) begin
          state_d = RX;
          crc_d   = crc_step;
          cnt_d   = BCW'(1);
        end
      end
      RX: begin
        if (axiiv) begin
          crc_d = crc_step;
          cnt_d = (cnt_q == SAT_CNT) ? cnt_q : cnt_q + BCW'(1);
        end else begin
          state_d = IDLE;
          report  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bytes = 32'(cnt_q) >> BYTE_SHIFT;

  always_comb begin
    err_now       = '0;
    err_now.fcs   = (crc_q != RESIDUE);
    err_now.runt  = (bytes < MIN_BYTES);
    err_now.giant = (bytes > MAX_BYTES);
    err_now.align = ((cnt_q & ALIGN_MASK) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= report;
      if (report) begin
        err_q <= err_now;
        if (|err_now) begin
          if (~&bad_q) bad_q <= bad_q + CNT_W'(1);
        end else begin
          if (~&good_q) good_q <= good_q + CNT_W'(1);
        end
      end
    end
  end

  assign done      = done_q;
  assign kill      = |err_q;
  assign err_fcs   = err_q.fcs;
  assign err_runt  = err_q.runt;
  assign err_giant = err_q.giant;
  assign err_align = err_q.align;
  assign good_cnt  = good_q;
  assign bad_cnt   = bad_q;

endmodule

// File: tb/tb_fcs_checker.sv
// Directed bench for fcs_checker. Four instances share clock and reset:
//   0: DW=8, MIN_BYTES=4     (reference frame, back-to-back, mid-frame reset)
//   1: DW=2, MIN_BYTES=4     (dibit reference frame, bit flip, alignment)
//   2: DW=8, defaults        (runt/giant length boundaries)
//   3: DW=8, MIN_BYTES=4, CNT_W=2  (counter saturation)
module tb_fcs_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld [4];
  logic [7:0]  dat [4];
  logic [1:0]  dib;
  logic        done_w [4];
  logic        kill_w [4];
  logic        ef [4], er [4], eg [4], ea [4];
  logic [15:0] good_w [3], bad_w [3];
  logic [1:0]  good_s, bad_s;

  fcs_checker #(.DW(8), .MIN_BYTES(4)) u_a (
    .clk(clk), .rst(rst), .axiiv(vld[0]), .axiid(dat[0]),
    .done(done_w[0]), .kill(kill_w[0]), .err_fcs(ef[0]), .err_runt(er[0]),
    .err_giant(eg[0]), .err_align(ea[0]), .good_cnt(good_w[0]), .bad_cnt(bad_w[0]));

  fcs_checker #(.DW(2), .MIN_BYTES(4)) u_b (
    .clk(clk), .rst(rst), .axiiv(vld[1]), .axiid(dib),
    .done(done_w[1]), .kill(kill_w[1]), .err_fcs(ef[1]), .err_runt(er[1]),
    .err_giant(eg[1]), .err_align(ea[1]), .good_cnt(good_w[1]), .bad_cnt(bad_w[1]));

  fcs_checker #(.DW(8)) u_c (
    .clk(clk), .rst(rst), .axiiv(vld[2]), .axiid(dat[2]),
    .done(done_w[2]), .kill(kill_w[2]), .err_fcs(ef[2]), .err_runt(er[2]),
    .err_giant(eg[2]), .err_align(ea[2]), .good_cnt(good_w[2]), .bad_cnt(bad_w[2]));

  fcs_checker #(.DW(8), .MIN_BYTES(4), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .axiiv(vld[3]), .axiid(dat[3]),
    .done(done_w[3]), .kill(kill_w[3]), .err_fcs(ef[3]), .err_runt(er[3]),
    .err_giant(eg[3]), .err_align(ea[3]), .good_cnt(good_s), .bad_cnt(bad_s));

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int dq [$];
  logic [7:0] frm [0:1599];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done_w[0] === 1'b1) dq.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Standard byte-wise CRC-32; FCS on the wire is the complement, LSB byte first.
  function automatic logic [31:0] crc_ref(input int unsigned n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_frame(input int unsigned n);
    logic [31:0] fcs;
    for (int unsigned i = 0; i < n - 4; i++) frm[i] = 8'((i * 37 + 5) & 255);
    fcs = ~crc_ref(n - 4);
    frm[n-4] = fcs[7:0];
    frm[n-3] = fcs[15:8];
    frm[n-2] = fcs[23:16];
    frm[n-1] = fcs[31:24];
  endtask

  // "123456789" followed by its known FCS bytes.
  task automatic load_check_frame();
    for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
    frm[9]  = 8'h26;
    frm[10] = 8'h39;
    frm[11] = 8'hF4;
    frm[12] = 8'hCB;
  endtask

  task automatic beat(input int unsigned w, input logic [7:0] d);
    @(posedge clk); #1;
    vld[w] = 1'b1;
    if (w == 1) dib = d[1:0];
    else        dat[w] = d;
  endtask

  task automatic idle(input int unsigned w);
    @(posedge clk); #1;
    vld[w] = 1'b0;
    if (w == 1) dib = '0;
    else        dat[w] = '0;
  endtask

  task automatic send(input int unsigned w, input int unsigned n, input int unsigned extra);
    for (int unsigned i = 0; i < n; i++) begin
      if (w == 1) begin
        for (int k = 0; k < 4; k++) beat(w, {6'b0, frm[i][2*k +: 2]});
      end else begin
        beat(w, frm[i]);
      end
    end
    for (int unsigned e = 0; e < extra; e++) beat(w, 8'h00);
  endtask

  // Idle cycle N must show no done; cycle N+1 must show the pulse.
  task automatic end_frame(input int unsigned w, input string tag);
    idle(w);
    @(negedge clk); chk({tag, "_done_early"}, 32'(done_w[w]), 32'd0);
    @(negedge clk); chk({tag, "_done"}, 32'(done_w[w]), 32'd1);
  endtask

  function automatic logic [31:0] gcnt(input int unsigned w);
    if (w == 3) return 32'(good_s);
    return 32'(good_w[w]);
  endfunction

  function automatic logic [31:0] bcnt(input int unsigned w);
    if (w == 3) return 32'(bad_s);
    return 32'(bad_w[w]);
  endfunction

  // errs packed as {fcs, runt, giant, align}
  task automatic report(input int unsigned w, input string tag, input logic [3:0] errs,
                        input logic k, input int unsigned g, input int unsigned b);
    chk({tag, "_err"}, 32'({ef[w], er[w], eg[w], ea[w]}), 32'(errs));
    chk({tag, "_kill"}, 32'(kill_w[w]), 32'(k));
    chk({tag, "_good"}, gcnt(w), g);
    chk({tag, "_bad"}, bcnt(w), b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin vld[i] = 1'b0; dat[i] = '0; end
    dib = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin vld[i] = 1'b0; dat[i] = '0; end
    dib = '0;
    do_reset();

    @(negedge clk);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_kill", 32'(kill_w[0]), 32'd0);
    chk("rst_good", gcnt(0), 32'd0);
    chk("rst_bad", bcnt(0), 32'd0);
    chk("rst_bad_sat", bcnt(3), 32'd0);

    // Reference frame, byte-wide
    load_check_frame();
    send(0, 13, 0);
    end_frame(0, "a_good");
    report(0, "a_good", 4'b0000, 1'b0, 1, 0);
    @(negedge clk); chk("a_done_clear", 32'(done_w[0]), 32'd0);

    // Same frame as dibits, then a single flipped bit in byte 3
    send(1, 13, 0);
    end_frame(1, "b_good");
    report(1, "b_good", 4'b0000, 1'b0, 1, 0);
    frm[3] = frm[3] ^ 8'h04;
    send(1, 13, 0);
    end_frame(1, "b_flip");
    report(1, "b_flip", 4'b1000, 1'b1, 1, 1);

    // Length boundaries with default limits
    build_frame(60);
    send(2, 60, 0);
    end_frame(2, "c_60");
    report(2, "c_60", 4'b0100, 1'b1, 0, 1);
    build_frame(1523);
    send(2, 1523, 0);
    end_frame(2, "c_1523");
    report(2, "c_1523", 4'b0010, 1'b1, 0, 2);
    build_frame(64);
    send(2, 64, 0);
    end_frame(2, "c_64");
    report(2, "c_64", 4'b0000, 1'b0, 1, 2);
    build_frame(1522);
    send(2, 1522, 0);
    end_frame(2, "c_1522");
    report(2, "c_1522", 4'b0000, 1'b0, 2, 2);

    // Valid 64-byte frame plus one stray dibit
    build_frame(64);
    send(1, 64, 1);
    end_frame(1, "b_align");
    chk("b_align_bit", 32'(ea[1]), 32'd1);
    chk("b_align_kill", 32'(kill_w[1]), 32'd1);
    chk("b_align_bad", bcnt(1), 32'd2);

    // Bad-counter saturation at CNT_W=2
    load_check_frame();
    frm[5] = frm[5] ^ 8'h80;
    for (int k = 1; k <= 5; k++) begin
      send(3, 13, 0);
      end_frame(3, "d_sat");
      chk("d_sat_bad", bcnt(3), (k < 3) ? 32'(k) : 32'd3);
    end
    chk("d_sat_good", gcnt(3), 32'd0);
    chk("d_sat_fcs", 32'(ef[3]), 32'd1);

    // Back-to-back frames with a single idle cycle between them
    do_reset();
    dq.delete();
    load_check_frame();
    send(0, 13, 0);
    idle(0);
    build_frame(20);
    send(0, 20, 0);
    idle(0);
    repeat (4) @(negedge clk);
    chk("b2b_pulses", 32'(dq.size()), 32'd2);
    chk("b2b_gap", (dq.size() == 2) ? 32'(dq[1] - dq[0]) : 32'hFFFFFFFF, 32'd21);
    chk("b2b_good", gcnt(0), 32'd2);
    chk("b2b_kill", 32'(kill_w[0]), 32'd0);

    // Reset in the middle of a frame discards it silently
    dq.delete();
    build_frame(64);
    send(0, 10, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_no_done", 32'(dq.size()), 32'd0);
    chk("mrst_good", gcnt(0), 32'd0);
    chk("mrst_bad", bcnt(0), 32'd0);
    chk("mrst_kill", 32'(kill_w[0]), 32'd0);
    send(0, 64, 0);
    end_frame(0, "mrst_after");
    report(0, "mrst_after", 4'b0000, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
